// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I widths and types
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/decoder_5_to_32.sv
// rtl/decoder_5_to_32.sv - 5-bit address to 32-bit one-hot select
module decoder_5_to_32
  import riscv_pkg::*;
(
  input  reg_addr_t             i_addr,
  output logic [NUM_REGS-1:0]   o_onehot
);

  assign o_onehot = NUM_REGS'(1) << i_addr;

endmodule

// File: rtl/regfile_32x32.sv
// rtl/regfile_32x32.sv - RV32I register file, 2 read + 1 write + debug read, write counter
module regfile_32x32 #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int BYPASS = 0,
  parameter int CNT_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] rs1_addr,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]             rs1_data,
  output logic [XLEN-1:0]             rs2_data,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]             rd_data,
  input  logic                        rd_wren,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]             dbg_data,
  output logic [CNT_W-1:0]            wr_count
);

  import riscv_pkg::*;

  logic [XLEN-1:0]     r_regs [1:NUM_REGS-1];
  logic [CNT_W-1:0]    r_wr_count;
  logic [NUM_REGS-1:0] w_onehot;
  logic [NUM_REGS-1:0] w_wen;
  logic [XLEN-1:0]     w_rd_vec [0:NUM_REGS-1];
  logic                w_fwd1;
  logic                w_fwd2;

  decoder_5_to_32 u_dec (
    .i_addr   (rd_addr),
    .o_onehot (w_onehot)
  );

  // Bit 0 masked off so x0 can never be written or counted.
  assign w_wen = (w_onehot & {NUM_REGS{rd_wren}}) & ~NUM_REGS'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_wr_count <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_wen[i]) r_regs[i] <= rd_data;
      end
      if (|w_wen) r_wr_count <= r_wr_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_rd_vec[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) w_rd_vec[i] = r_regs[i];
  end

  assign w_fwd1 = (BYPASS != 0) && rd_wren && (rd_addr != '0) && (rs1_addr == rd_addr);
  assign w_fwd2 = (BYPASS != 0) && rd_wren && (rd_addr != '0) && (rs2_addr == rd_addr);

  assign rs1_data = w_fwd1 ? rd_data : w_rd_vec[rs1_addr];
  assign rs2_data = w_fwd2 ? rd_data : w_rd_vec[rs2_addr];
  assign dbg_data = w_rd_vec[dbg_addr];
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_regfile_32x32.sv
// tb/tb_regfile_32x32.sv - self-checking bench: three regfile variants against an array model
module tb_regfile_32x32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0, rd_addr = '0, dbg_addr = '0;
  logic [31:0] rd_data = '0;
  logic        rd_wren = 1'b0;

  logic [31:0] a_rs1, a_rs2, a_dbg, a_cnt;
  logic [31:0] b_rs1, b_rs2, b_dbg, b_cnt;
  logic [31:0] c_rs1, c_rs2, c_dbg;
  logic [3:0]  c_cnt;

  logic [31:0] m_regs [32];
  logic [31:0] m_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_32x32 #(.BYPASS(0), .CNT_W(32)) u_plain (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(a_rs1), .rs2_data(a_rs2), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_wren(rd_wren), .dbg_addr(dbg_addr), .dbg_data(a_dbg), .wr_count(a_cnt)
  );

  regfile_32x32 #(.BYPASS(1), .CNT_W(32)) u_byp (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b_rs1), .rs2_data(b_rs2), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_wren(rd_wren), .dbg_addr(dbg_addr), .dbg_data(b_dbg), .wr_count(b_cnt)
  );

  regfile_32x32 #(.BYPASS(0), .CNT_W(4)) u_cnt4 (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(c_rs1), .rs2_data(c_rs2), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_wren(rd_wren), .dbg_addr(dbg_addr), .dbg_data(c_dbg), .wr_count(c_cnt)
  );

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : m_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_count = 32'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst && rd_wren && rd_addr != 5'd0) begin
      m_regs[rd_addr] = rd_data;
      m_count = m_count + 32'd1;
    end
    #1;
  endtask

  task automatic drive(input logic wren, input logic [4:0] rd, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
    rd_wren = wren; rd_addr = rd; rd_data = d;
    rs1_addr = r1; rs2_addr = r2; dbg_addr = dbg;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e1, e2, ed, f1, f2;
    #1;
    e1 = model_rd(rs1_addr);
    e2 = model_rd(rs2_addr);
    ed = model_rd(dbg_addr);
    f1 = (rd_wren && rd_addr != 5'd0 && rs1_addr == rd_addr) ? rd_data : e1;
    f2 = (rd_wren && rd_addr != 5'd0 && rs2_addr == rd_addr) ? rd_data : e2;
    chk({tag, ".plain.rs1"}, a_rs1, e1);
    chk({tag, ".plain.rs2"}, a_rs2, e2);
    chk({tag, ".plain.dbg"}, a_dbg, ed);
    chk({tag, ".plain.cnt"}, a_cnt, m_count);
    chk({tag, ".byp.rs1"},   b_rs1, f1);
    chk({tag, ".byp.rs2"},   b_rs2, f2);
    chk({tag, ".byp.dbg"},   b_dbg, ed);
    chk({tag, ".byp.cnt"},   b_cnt, m_count);
    chk({tag, ".cnt4.rs1"},  c_rs1, e1);
    chk({tag, ".cnt4.cnt"},  {28'd0, c_cnt}, {28'd0, m_count[3:0]});
  endtask

  initial begin
    model_clear();
    check_all("reset_init");
    #12 rst = 1'b0;
    #1;

    // Async reset mid-cycle after writing x5
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5);
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5);
    check_all("x5_written");
    #2 rst = 1'b1;
    model_clear();
    check_all("async_reset");
    chk("async_reset.rs1_x5", a_rs1, 32'd0);
    tick();
    rst = 1'b0;

    // Basic write/read
    drive(1'b1, 5'd1, 32'h12345678, 5'd1, 5'd31, 5'd1);
    tick();
    drive(1'b1, 5'd31, 32'hFFFFFFFF, 5'd1, 5'd31, 5'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd31, 5'd31);
    check_all("basic");
    chk("basic.rs1_x1", a_rs1, 32'h12345678);
    chk("basic.rs2_x31", a_rs2, 32'hFFFFFFFF);
    chk("basic.count2", a_cnt, 32'd2);

    // x0 write discarded
    drive(1'b1, 5'd0, 32'hAAAA5555, 5'd0, 5'd0, 5'd0);
    check_all("x0_same_cycle");
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    check_all("x0_after");
    chk("x0.count_unchanged", a_cnt, 32'd2);

    // Bypass vs non-bypass on x7
    drive(1'b1, 5'd7, 32'h1, 5'd7, 5'd7, 5'd7);
    tick();
    drive(1'b1, 5'd7, 32'h2, 5'd7, 5'd3, 5'd7);
    check_all("bypass_same_cycle");
    chk("bypass.byp_rs1", b_rs1, 32'h2);
    chk("bypass.plain_rs1", a_rs1, 32'h1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7);
    check_all("bypass_next_cycle");
    chk("bypass.plain_rs1_next", a_rs1, 32'h2);

    // Write presented during reset is dropped
    rst = 1'b1;
    model_clear();
    drive(1'b1, 5'd3, 32'h99, 5'd3, 5'd3, 5'd3);
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 5'd3);
    tick();
    check_all("reset_vs_write");
    chk("reset_vs_write.x3", a_rs1, 32'd0);
    chk("reset_vs_write.count", a_cnt, 32'd0);

    // Sweep x1..x31 with value = index; 4-bit counter wraps after 16
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i), 5'(i), 5'd0, 5'(i));
      tick();
      if (i == 17) begin
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        #1 chk("wrap.cnt4_17", {28'd0, c_cnt}, 32'd1);
      end
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(31 - i), 5'(i), 5'(i));
      #1 chk("sweep.dbg", a_dbg, 32'(i));
      check_all("sweep");
    end

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [4:0] w_rd, w_r1;
      w_rd = 5'($urandom_range(0, 31));
      w_r1 = ($urandom_range(0, 3) == 0) ? w_rd : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), w_rd, $urandom(), w_r1,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      check_all("random");
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    check_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
